// File: rtl/spike_delay_scheduler.sv
// Spike delay scheduler: captures per-channel spike edges, grants them
// round-robin and replays each on a shared output after a per-channel delay.
// Ports: clk, rst (async, active-low); spike_in[N_CH] spike levels;
// cfg_we/cfg_ch/cfg_dly delay register write; ovf_clr clears overflow;
// out_spike/out_ch registered fire pulse; busy while counting or firing;
// pending captured events; overflow sticky dropped-event flags.
module spike_delay_scheduler #(
  parameter int N_CH    = 4,
  parameter int DLY_W   = 4,
  parameter int DLY_RST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         spike_in,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [DLY_W-1:0]        cfg_dly,
  input  logic                    ovf_clr,
  output logic                    out_spike,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    busy,
  output logic [N_CH-1:0]         pending,
  output logic [N_CH-1:0]         overflow
);

  localparam int CW = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [N_CH-1:0]   prev;
  logic [N_CH-1:0]   edge_det;
  logic [N_CH-1:0]   gmask;
  logic [DLY_W-1:0]  dly [N_CH];
  logic [DLY_W-1:0]  cnt;
  logic [DLY_W-1:0]  cnt_n;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     ptr_n;
  logic [CW-1:0]     gsel;
  logic [CW-1:0]     gsel_n;
  logic [CW-1:0]     gnt_ch;
  logic [CW-1:0]     idx;
  logic              gnt_found;
  logic              grant;
  logic              cfg_ok;

  assign edge_det = spike_in & ~prev;
  assign cfg_ok   = int'(cfg_ch) < N_CH;
  assign gmask    = grant ? (N_CH'(1) << gnt_ch) : '0;

  // First pending channel at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CW'((int'(ptr) + k) % N_CH);
      if (!gnt_found && pending[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gsel_n  = gsel;
    ptr_n   = ptr;
    grant   = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_found) begin
          grant   = 1'b1;
          gsel_n  = gnt_ch;
          ptr_n   = CW'((int'(gnt_ch) + 1) % N_CH);
          // Delay sampled here; later writes never reach this event.
          cnt_n   = dly[gnt_ch];
          state_n = (dly[gnt_ch] == '0) ? FIRE : COUNT;
        end
      end
      COUNT: begin
        if (cnt == DLY_W'(1)) state_n = FIRE;
        else cnt_n = cnt - DLY_W'(1);
      end
      FIRE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      ptr       <= '0;
      gsel      <= '0;
      prev      <= '0;
      pending   <= '0;
      overflow  <= '0;
      out_spike <= 1'b0;
      out_ch    <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dly[i] <= DLY_W'(DLY_RST);
      end
    end else begin
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      gsel     <= gsel_n;
      prev     <= spike_in;
      // A new edge re-arms even the channel granted this cycle.
      pending  <= (pending & ~gmask) | edge_det;
      overflow <= (overflow & ~{N_CH{ovf_clr}})
                | (edge_det & pending & ~gmask);
      if (cfg_we && cfg_ok) dly[cfg_ch] <= cfg_dly;
      out_spike <= (state_n == FIRE);
      out_ch    <= (state_n == FIRE) ? gsel_n : '0;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_spike_delay_scheduler.sv
// Bench for spike_delay_scheduler: directed scenarios plus random traffic
// against a timestamp-based reference model.
module tb_spike_delay_scheduler;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int DW = 4;
  localparam int DR = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  spike_in;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [DW-1:0] cfg_dly;
  logic          ovf_clr;
  logic          out_spike;
  logic [CW-1:0] out_ch;
  logic          busy;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int           c = 0;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovf;
  int           m_dly [N];
  int           m_ptr;
  int           g_cyc;
  int           f_cyc;
  int           f_ch;

  int fire_ch[$];
  int fire_t[$];

  always #5 clk = ~clk;

  spike_delay_scheduler #(
    .N_CH(N),
    .DLY_W(DW),
    .DLY_RST(DR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spike_in(spike_in),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_dly(cfg_dly),
    .ovf_clr(ovf_clr),
    .out_spike(out_spike),
    .out_ch(out_ch),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_pend = '0;
    m_ovf  = '0;
    m_ptr  = 0;
    g_cyc  = -100;
    f_cyc  = -100;
    f_ch   = 0;
    for (int i = 0; i < N; i++) m_dly[i] = DR;
  endtask

  // One event in flight: granted at g_cyc, fires at f_cyc = g_cyc + delay.
  // A new grant is possible two cycles after the previous fire.
  task automatic model_step();
    logic [N-1:0] e;
    logic [N-1:0] gm;
    int gi;
    int j;
    c++;
    if (!rst) begin
      model_reset();
    end else begin
      e  = spike_in & ~m_prev;
      gm = '0;
      gi = -1;
      if (c >= f_cyc + 2) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (gi < 0 && m_pend[j]) gi = j;
        end
        if (gi >= 0) begin
          gm[gi] = 1'b1;
          g_cyc  = c;
          f_cyc  = c + m_dly[gi];
          f_ch   = gi;
          m_ptr  = (gi + 1) % N;
        end
      end
      m_ovf  = (ovf_clr ? '0 : m_ovf) | (e & m_pend & ~gm);
      m_pend = (m_pend & ~gm) | e;
      if (cfg_we && int'(cfg_ch) < N) m_dly[cfg_ch] = int'(cfg_dly);
      m_prev = spike_in;
    end
  endtask

  task automatic check_all(input string ph);
    logic eo;
    eo = (c == f_cyc);
    chk({ph, ".out_spike"}, 32'(out_spike), 32'(eo));
    chk({ph, ".out_ch"}, 32'(out_ch), eo ? f_ch : 0);
    chk({ph, ".busy"}, 32'(busy), 32'(c >= g_cyc && c <= f_cyc));
    chk({ph, ".pending"}, 32'(pending), 32'(m_pend));
    chk({ph, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick(input string ph = "run");
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
    if (out_spike === 1'b1) begin
      fire_ch.push_back(int'(out_ch));
      fire_t.push_back(c);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = CW'(ch);
    cfg_dly = DW'(d);
    tick("wr");
    cfg_we  = 1'b0;
  endtask

  // Returns the capture edge index of the rising edge.
  task automatic pulse(input logic [N-1:0] m, output int cap);
    spike_in = m;
    tick("pulse");
    cap = c;
    spike_in = '0;
    tick("pulse");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    tick("rst_hold");
    rst = 1'b1;
  endtask

  task automatic clr_log();
    fire_ch.delete();
    fire_t.delete();
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int cap;
    int cap2;
    int n1;
    rst      = 1'b1;
    spike_in = '0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_dly  = '0;
    ovf_clr  = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_all("reset");
    tick("reset");
    rst = 1'b1;
    run(2);

    // Single edge on ch2, default delay 1.
    clr_log();
    pulse(4'b0100, cap);
    run(6);
    chk("ch2_n", fire_t.size(), 1);
    chk("ch2_t", at(fire_t, 0), cap + 2);
    chk("ch2_ch", at(fire_ch, 0), 2);

    // Zero and long delays.
    wr(0, 0);
    wr(1, 5);
    clr_log();
    pulse(4'b0001, cap);
    pulse(4'b0010, cap2);
    run(10);
    chk("d0_t", at(fire_t, 0), cap + 1);
    chk("d0_ch", at(fire_ch, 0), 0);
    chk("d5_t", at(fire_t, 1), cap2 + 1 + 5);
    chk("d5_ch", at(fire_ch, 1), 1);

    // Round-robin bursts from ptr=0, all delays zero.
    do_reset();
    for (int i = 0; i < N; i++) wr(i, 0);
    for (int b = 0; b < 2; b++) begin
      clr_log();
      pulse(4'b1111, cap);
      run(10);
      chk("rr_n", fire_t.size(), 4);
      for (int i = 0; i < 4; i++) chk("rr_ch", at(fire_ch, i), i);
      for (int i = 0; i < 3; i++)
        chk("rr_gap", at(fire_t, i + 1) - at(fire_t, i), 2);
    end

    // Overflow on ch1 while ch0 counts a long delay.
    wr(0, 9);
    clr_log();
    pulse(4'b0001, cap);
    pulse(4'b0010, cap2);
    pulse(4'b0010, cap2);
    chk("ovf1", 32'(overflow[1]), 1);
    run(16);
    n1 = 0;
    foreach (fire_ch[i]) if (fire_ch[i] == 1) n1++;
    chk("ovf_one_fire", n1, 1);
    ovf_clr = 1'b1;
    tick("ovf_clr");
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Delay rewrite during an in-flight count.
    wr(3, 9);
    clr_log();
    pulse(4'b1000, cap);
    wr(3, 2);
    run(12);
    chk("old_dly_t", at(fire_t, 0), cap + 1 + 9);
    pulse(4'b1000, cap2);
    run(6);
    chk("new_dly_t", at(fire_t, 1), cap2 + 1 + 2);

    // Reset during COUNT aborts the event.
    wr(0, 9);
    pulse(4'b0001, cap);
    run(2);
    chk("cnt_busy", 32'(busy), 1);
    do_reset();
    clr_log();
    run(14);
    chk("abort_n", fire_t.size(), 0);
    pulse(4'b0100, cap);
    run(4);
    chk("rst_dly_t", at(fire_t, 0), cap + 2);

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      logic [N-1:0] fl;
      fl = '0;
      for (int i = 0; i < N; i++) fl[i] = ($urandom_range(0, 3) == 0);
      spike_in ^= fl;
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = CW'($urandom_range(0, N - 1));
      cfg_dly = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15))
                                            : DW'($urandom_range(0, 3));
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick("rand");
    end
    cfg_we   = 1'b0;
    ovf_clr  = 1'b0;
    spike_in = '0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
